// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, synchronous-ROM skid buffer and IF/ID register.
// Optional perf counters are built only when FETCH_PERF_CNT_EN is defined.
module mips_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned ROM_AW   = 8,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic              i_clk,
   input  logic              i_rst,
   output logic [ROM_AW-1:0] o_rom_addr,
   input  logic [31:0]       i_rom_data,
   input  logic              i_stall,
   input  logic              i_kill,
   input  logic [31:0]       i_redirect_pc,
   output logic [31:0]       o_pc,
   output logic [31:0]       o_ifid_instr,
   output logic [31:0]       o_ifid_pc4,
   output logic              o_ifid_valid,
   output logic [15:0]       o_stall_cycles,
   output logic [15:0]       o_kill_count
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] f_pc_q, f_pc_d;
   logic        f_valid_q, f_valid_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_word_q, skid_word_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc4_q, ifid_pc4_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] fw_s;
   logic        fv_s;

   assign o_rom_addr   = pc_q[ROM_AW+1:2];
   assign fw_s         = skid_valid_q ? skid_word_q : i_rom_data;
   assign fv_s         = skid_valid_q | f_valid_q;
   assign o_pc         = pc_q;
   assign o_ifid_instr = ifid_instr_q;
   assign o_ifid_pc4   = ifid_pc4_q;
   assign o_ifid_valid = ifid_valid_q;

   always_comb begin
      pc_d         = pc_q;
      f_pc_d       = pc_q;
      f_valid_d    = 1'b1;
      skid_valid_d = skid_valid_q;
      skid_word_d  = skid_word_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
      if (i_kill) begin
         pc_d         = i_redirect_pc & 32'hFFFF_FFFC;
         f_valid_d    = 1'b0;
         skid_valid_d = 1'b0;
         ifid_instr_d = NOP_WORD;
         ifid_pc4_d   = 32'h0000_0000;
         ifid_valid_d = 1'b0;
      end else if (i_stall) begin
         // f_pc is kept so the skid word retains the PC it was fetched from
         f_pc_d    = f_pc_q;
         f_valid_d = 1'b0;
         if (!skid_valid_q && f_valid_q) begin
            skid_word_d  = i_rom_data;
            skid_valid_d = 1'b1;
         end else begin
            skid_word_d  = skid_word_q;
            skid_valid_d = skid_valid_q;
         end
      end else begin
         ifid_instr_d = fw_s;
         ifid_pc4_d   = f_pc_q + 32'd4;
         ifid_valid_d = fv_s;
         skid_valid_d = 1'b0;
         // Draining the skid: hold pc one cycle so its word is re-read cleanly
         if (skid_valid_q) begin
            pc_d      = pc_q;
            f_valid_d = 1'b0;
         end else begin
            pc_d = pc_q + 32'd4;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pc_q         <= RESET_PC;
         f_pc_q       <= 32'h0000_0000;
         f_valid_q    <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_word_q  <= 32'h0000_0000;
         ifid_instr_q <= NOP_WORD;
         ifid_pc4_q   <= 32'h0000_0000;
         ifid_valid_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         f_pc_q       <= f_pc_d;
         f_valid_q    <= f_valid_d;
         skid_valid_q <= skid_valid_d;
         skid_word_q  <= skid_word_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] kill_cnt_q, kill_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      kill_cnt_d  = kill_cnt_q;
      if (i_kill) begin
         if (kill_cnt_q != 16'hFFFF) begin
            kill_cnt_d = kill_cnt_q + 16'd1;
         end else begin
            kill_cnt_d = kill_cnt_q;
         end
      end else if (i_stall) begin
         if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
         end else begin
            stall_cnt_d = stall_cnt_q;
         end
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stall_cnt_q <= 16'h0000;
         kill_cnt_q  <= 16'h0000;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         kill_cnt_q  <= kill_cnt_d;
      end
   end

   assign o_stall_cycles = stall_cnt_q;
   assign o_kill_count   = kill_cnt_q;
`else
   assign o_stall_cycles = 16'h0000;
   assign o_kill_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Scoreboard bench for mips_fetch_stage: expected IF/ID stream is the sequential word stream
// restarting at each reset/kill target; a monitor pops and compares every new valid IF/ID entry.
module tb_mips_fetch_stage;
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, stall, kill;
   logic [31:0] redirect, rom_data, pc, instr, pc4;
   logic [7:0]  rom_addr;
   logic        valid;
   logic [15:0] sc, kc;

   int   checks = 0;
   int   errs   = 0;
   int   pops   = 0;
   exp_t exp_q[$];
   logic [31:0] next_push_pc = 32'h0;

   // values seen at the last rising edge
   logic        e_rst = 1'b1, e_kill = 1'b0, e_stall = 1'b0;
   logic [31:0] e_tgt = 32'h0;
   int          sc_m = 0, kc_m = 0;
   logic [31:0] prev_pc = 32'h0, prev_instr = 32'h0, prev_pc4 = 32'h0;
   logic        prev_valid = 1'b0;

   mips_fetch_stage dut (
      .i_clk(clk), .i_rst(rst), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
      .i_stall(stall), .i_kill(kill), .i_redirect_pc(redirect), .o_pc(pc),
      .o_ifid_instr(instr), .o_ifid_pc4(pc4), .o_ifid_valid(valid),
      .o_stall_cycles(sc), .o_kill_count(kc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= 32'hA000_0000 + {24'h0, rom_addr};

   function automatic logic [31:0] ref_word(input logic [31:0] p);
      return 32'hA000_0000 + ((p >> 2) & 32'h0000_00FF);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic top_up();
      exp_t e;
      while (exp_q.size() < 8) begin
         e.instr = ref_word(next_push_pc);
         e.pc4   = next_push_pc + 32'd4;
         exp_q.push_back(e);
         next_push_pc = next_push_pc + 32'd4;
      end
   endtask

   task automatic restart(input logic [31:0] target);
      exp_q.delete();
      next_push_pc = target;
      top_up();
   endtask

   task automatic step();
      @(negedge clk);
      #1;
      top_up();
   endtask

   always @(posedge clk) begin
      e_rst   <= rst;
      e_kill  <= kill;
      e_stall <= stall;
      e_tgt   <= redirect & 32'hFFFF_FFFC;
      if (rst) begin
         sc_m <= 0;
         kc_m <= 0;
      end else if (kill) begin
         if (kc_m < 65535) kc_m <= kc_m + 1;
      end else if (stall) begin
         if (sc_m < 65535) sc_m <= sc_m + 1;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!e_rst && !rst) begin
         if (e_kill) begin
            check("kill_valid", 32'(valid), 32'h0);
            check("kill_instr", instr, 32'h0);
            check("kill_pc", pc, e_tgt);
         end else if (e_stall) begin
            check("hold_pc", pc, prev_pc);
            check("hold_instr", instr, prev_instr);
            check("hold_pc4", pc4, prev_pc4);
            check("hold_valid", 32'(valid), 32'(prev_valid));
         end else if (valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errs++;
               $display("FAIL underflow: got instr %h expected none", instr);
            end else begin
               e = exp_q.pop_front();
               pops++;
               check("stream_instr", instr, e.instr);
               check("stream_pc4", pc4, e.pc4);
            end
         end
`ifdef FETCH_PERF_CNT_EN
         check("stall_cycles", 32'(sc), 32'(sc_m));
         check("kill_count", 32'(kc), 32'(kc_m));
`else
         check("stall_cycles", 32'(sc), 32'h0);
         check("kill_count", 32'(kc), 32'h0);
`endif
      end
      prev_pc    <= pc;
      prev_instr <= instr;
      prev_pc4   <= pc4;
      prev_valid <= valid;
   end

   initial begin
      rst = 1'b1; stall = 1'b0; kill = 1'b0; redirect = 32'h0;
      step(); step();
      check("rst_pc", pc, 32'h0);
      check("rst_valid", 32'(valid), 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_pc4", pc4, 32'h0);
      check("rst_sc", 32'(sc), 32'h0);
      check("rst_kc", 32'(kc), 32'h0);
      restart(32'h0);
      rst = 1'b0;
      step(); check("lat_e1_valid", 32'(valid), 32'h0);
      step(); check("lat_e2_valid", 32'(valid), 32'h1);
      step(); step(); check("pre_stall_instr", instr, 32'hA000_0002);

      // 3-cycle stall, skid must deliver A3 then one refill bubble then A4
      stall = 1'b1;
      repeat (3) begin step(); check("stall_instr", instr, 32'hA000_0002); end
      stall = 1'b0;
      step(); check("skid_instr", instr, 32'hA000_0003); check("skid_pc4", pc4, 32'd16);
      step(); check("refill_bubble", 32'(valid), 32'h0);
      step(); check("after_refill", instr, 32'hA000_0004);

      // kill to 0x40
      kill = 1'b1; redirect = 32'h40; restart(32'h40);
      step(); kill = 1'b0;
      step();
      step(); check("kill_tgt_instr", instr, 32'hA000_0010); check("kill_tgt_pc4", pc4, 32'h44);

      // kill+stall with a full skid
      stall = 1'b1; step(); step();
      kill = 1'b1; redirect = 32'h80; restart(32'h80);
      step(); check("ks_pc", pc, 32'h80);
      kill = 1'b0; stall = 1'b0;
      step(); check("ks_bubble", 32'(valid), 32'h0);
      step(); check("ks_instr", instr, 32'hA000_0020);

      // async reset mid-stall with full skid
      stall = 1'b1; step(); step();
      rst = 1'b1; stall = 1'b0;
      #1;
      check("arst_pc", pc, 32'h0);
      check("arst_valid", 32'(valid), 32'h0);
      restart(32'h0);
      step();
      rst = 1'b0;
      step(); step(); check("arst_restart", instr, 32'hA000_0000);
      repeat (3) step();

      // randomized stall/kill traffic
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 99);
         stall = (r < 25);
         kill  = (r >= 96) || (r == 0);
         if (kill) begin
            redirect = $urandom();
            restart(redirect & 32'hFFFF_FFFC);
         end
         step();
      end
      stall = 1'b0; kill = 1'b0;
      repeat (4) step();
      checks++;
      if (pops < 500) begin
         errs++;
         $display("FAIL throughput: got %0d entries expected at least 500", pops);
      end

`ifdef FETCH_PERF_CNT_EN
      stall = 1'b1;
      repeat (70000) step();
      check("stall_sat", 32'(sc), 32'h0000_FFFF);
      stall = 1'b0;
      step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end
endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline; sits directly upstream of the decode stage inside main_datapath.
- Owns the PC register and drives the instruction ROM, which has a synchronous, 1-cycle-latency read.
- Loads the IF/ID pipeline register.
- Obeys stall and kill from the hazard unit; kill redirects the PC.
- A skid register keeps the in-flight ROM word when a stall arrives.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ROM_AW, 8, ROM word-address width; o_rom_addr = PC[ROM_AW+1:2].
- NOP_WORD, 32'h0000_0000, instruction inserted into IF/ID on reset or kill (sll $0,$0,0).

Ports:
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  asynchronous, active-high reset.
- o_rom_addr  out  ROM_AW  word address presented to the ROM this cycle.
- i_rom_data  in  32  ROM word for the address presented at the previous rising edge.
- i_stall  in  1  hold the PC and IF/ID (load-use hazard).
- i_kill  in  1  flush the fetch path and IF/ID; redirect the PC.
- i_redirect_pc  in  32  target PC, sampled when i_kill=1.
- o_pc  out  32  current PC register.
- o_ifid_instr  out  32  IF/ID instruction.
- o_ifid_pc4  out  32  IF/ID PC+4 of that instruction.
- o_ifid_valid  out  1  IF/ID holds a real instruction.
- o_stall_cycles  out  16  perf counter (see Optional Feature).
- o_kill_count  out  16  perf counter (see Optional Feature).

Behaviour:
Reset (asynchronous, takes effect immediately):
- pc=RESET_PC.
- f_pc=0, f_valid=0, skid_valid=0, skid_word=0.
- o_ifid_instr=NOP_WORD, o_ifid_pc4=0, o_ifid_valid=0, counters=0.
- Deasserting i_rst mid-operation restarts fetch from RESET_PC; there is no partial state.

ROM addressing:
- o_rom_addr = pc[ROM_AW+1:2], combinational.
- f_pc and f_valid track the word that i_rom_data returns this cycle: at each edge, f_pc<=pc and f_valid<=1, except in the kill and stall rows below.
- The current fetched word is fw = skid_valid ? skid_word : i_rom_data.
- The current fetched valid is fv = skid_valid | f_valid.

Per-edge priority (highest first):
1. i_kill=1:
   - pc<=i_redirect_pc; f_valid<=0; skid_valid<=0.
   - IF/ID<=NOP_WORD, pc4=0, valid=0.
   - Kill overrides a simultaneous i_stall.
2. i_stall=1 (state HOLD):
   - pc and IF/ID hold.
   - If skid_valid=0 and f_valid=1: skid_word<=i_rom_data, skid_valid<=1.
   - f_valid<=0 (the re-read of the held pc is discarded; the skid keeps the real word).
3. Otherwise (state RUN):
   - IF/ID<={fw, f_pc+4 (skid path uses the captured f_pc), fv}; skid_valid<=0.
   - If skid_valid=1 on this edge, hold pc and set f_valid<=0 so the word at the current pc is re-fetched cleanly. Otherwise pc<=pc+4.

Timing and arithmetic:
- Latency: the instruction at PC p appears in IF/ID 2 edges after pc=p, assuming no stall.
- Throughput: 1 instruction/cycle.
- A stall costs exactly its own length plus 1 refill cycle after release.
- pc+4 wraps modulo 2^32.
- The ROM address silently aliases above 2^(ROM_AW+2) bytes.
- Bits [1:0] of i_redirect_pc are forced to 0.

States:
- RUN->HOLD on i_stall.
- HOLD->RUN on stall release.
- Any state->RUN on i_kill.
- The state is not encoded explicitly; it is derived from i_stall and skid_valid.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - o_stall_cycles increments on every edge with i_stall=1 and i_kill=0.
  - o_kill_count increments on every edge with i_kill=1.
  - Both are 16-bit, saturate at 16'hFFFF, and clear on reset.
- Undefined: both ports remain in the port list, tied to 16'h0; no counter flops are built.

Test Plan:
- Reset then run: ROM[k]=32'hA000_0000+k, RESET_PC=0. Expected: o_ifid_valid=1 from edge 2; o_ifid_instr sequence A0000000, A0000001, A0000002; o_ifid_pc4 sequence 4, 8, 12.
- Stall 3 cycles while IF/ID=A0000002. Expected: IF/ID holds for 3 cycles. After release: A0000003 from skid, then A0000004. No word is dropped or duplicated. With the macro defined, o_stall_cycles=3.
- Kill with i_redirect_pc=32'h40. Expected: next edge IF/ID valid=0, instr=NOP_WORD. After 2 edges: A0000010, pc4=32'h44. With the macro defined, o_kill_count=1.
- Kill and stall asserted together, i_redirect_pc=32'h80. Expected: kill wins; pc=32'h80; skid cleared; the next valid IF/ID word is A0000020.
- Async reset pulsed mid-stall with a full skid. Expected: immediately o_pc=0, o_ifid_valid=0; after release, fetch restarts at A0000000.
- Saturation (macro defined): hold i_stall for 70000 cycles. Expected: o_stall_cycles sticks at 16'hFFFF.
